pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central sequencer for pipeline stall, bubble and flush control in the 5-stage CPU.
- Merges three sources into one consistent set of latch-enable, flush and no-op controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - load-use hazard request from the hazard detection unit;
  - branch-taken flush from ID;
  - multi-cycle data-memory access tracked by an internal wait FSM and counter.

Parameters:
- MEM_LATENCY, 4, data-memory access latency in cycles; legal range 1..15; 1 means no memory stall.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  CPU run enable.
- hazard_i  in  1  load-use hazard request from the hazard detection unit.
- branch_taken_i  in  1  branch resolved taken in ID.
- mem_req_i  in  1  EX/MEM holds a load or store (MemRead|MemWrite).
- mem_start_o  out  1  one-cycle pulse that launches the data-memory access.
- mem_done_o  out  1  pulse on the cycle the access completes.
- pc_write_o  out  1  PC register write enable.
- ifid_write_o  out  1  IF/ID latch write enable.
- ifid_flush_o  out  1  IF/ID latch is loaded with a NOP.
- idex_noop_o  out  1  ID/EX control fields are zeroed (bubble).
- pipe_freeze_o  out  1  hold ID/EX and EX/MEM.
- memwb_noop_o  out  1  MEM/WB control fields are zeroed.
- stall_cycles_o  out  CNT_W  load-use stall cycle count (optional feature).
- flush_count_o  out  CNT_W  branch flush count (optional feature).
- mem_wait_cycles_o  out  CNT_W  memory freeze cycle count (optional feature).

Behaviour:
- Clocking and reset:
  - Single clock domain: clk_i, rising edge.
  - rst_i is synchronous, active-high.
  - While rst_i is high, every output is 0, state goes to RUN and cnt to 0.
  - Assertion mid-MEM_WAIT abandons the access; no mem_done_o is produced.
- FSM states: RUN, MEM_WAIT. 4-bit down-counter cnt.
- Transitions:
  - RUN, start_i=1 and mem_req_i=1:
    - pulse mem_start_o.
    - If MEM_LATENCY>1: load cnt=MEM_LATENCY-1 and go to MEM_WAIT.
    - If MEM_LATENCY==1: pulse mem_done_o in the same cycle; no freeze.
  - MEM_WAIT:
    - cnt>1: decrement cnt; stay in MEM_WAIT.
    - cnt==1: pulse mem_done_o; go to RUN.
- Freeze condition: mem_freeze = (RUN & start_i & mem_req_i & MEM_LATENCY>1) | (MEM_WAIT & cnt>1).
  - Total residency of one memory instruction in MEM = MEM_LATENCY cycles.
  - The instruction advances on the clock edge ending the mem_done_o cycle.
  - The next RUN cycle with mem_req_i=1 is therefore a new access. Back-to-back accesses carry no dead cycle.
- Output priority, evaluated combinationally each cycle:
  1. start_i=0 and state RUN: all enables 0, no flush, no no-op.
  2. mem_freeze=1:
     - pc_write_o=0, ifid_write_o=0, pipe_freeze_o=1, memwb_noop_o=1.
     - hazard_i and branch_taken_i are ignored. They are re-evaluated after release because the stages are held.
  3. hazard_i=1: pc_write_o=0, ifid_write_o=0, idex_noop_o=1. ifid_flush_o is suppressed even if branch_taken_i=1, because the branch waits for the load.
  4. branch_taken_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
  5. Otherwise: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- start_i dropping during MEM_WAIT: the counter keeps running to completion, freeze stays asserted, and mem_done_o still fires.
- mem_req_i dropping during MEM_WAIT: ignored; the access is committed.
- Combinational depth: no output depends combinationally on another output.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - Three CNT_W saturating counters, all cleared by rst_i.
  - stall_cycles_o increments on each cycle where priority 3 applies.
  - flush_count_o increments on each priority-4 cycle.
  - mem_wait_cycles_o increments on each cycle with mem_freeze=1.
  - Each counter holds at all-ones.
- Undefined: the ports remain present and are tied to 0; no counter flops are built.

Test Plan:
- Reset mid-wait: MEM_LATENCY=4, mem_req_i=1 at cycle 0, rst_i=1 at cycle 2 -> all outputs 0 during reset, no mem_done_o, state RUN with pc_write_o=1 after reset with start_i=1.
- Single load: MEM_LATENCY=4, mem_req_i=1 for 4 cycles -> mem_start_o at cycle 0; pipe_freeze_o=1 at cycles 0-2; mem_done_o and pc_write_o=1 at cycle 3.
- Back-to-back: MEM_LATENCY=4, two loads back-to-back -> mem_start_o at cycles 0 and 4; 6 freeze cycles total; mem_done_o at cycles 3 and 7.
- Load-use plus branch: hazard_i=1 and branch_taken_i=1 together -> idex_noop_o=1, ifid_flush_o=0, pc_write_o=0. Next cycle hazard_i=0 -> ifid_flush_o=1, pc_write_o=1.
- Freeze masks hazard: hazard_i=1 during MEM_WAIT -> idex_noop_o=0, pipe_freeze_o=1. After mem_done_o, with hazard_i still 1 -> idex_noop_o=1.
- Degenerate latency and counters: MEM_LATENCY=1, mem_req_i=1 -> mem_start_o and mem_done_o in the same cycle, never frozen. With STALL_PERF_CNT_EN and CNT_W=2: 5 hazard cycles -> stall_cycles_o=3.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/bubble/flush sequencer for the 5-stage pipeline: merges load-use, branch flush and memory wait.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    output logic             mem_start_o,
    output logic             mem_done_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_noop_o,
    output logic             pipe_freeze_o,
    output logic             memwb_noop_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic [CNT_W-1:0] mem_wait_cycles_o
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam bit         MULTI_CYCLE = (MEM_LATENCY > 1);
    localparam logic [3:0] LAT_M1      = 4'(MEM_LATENCY - 1);

    state_t     state_reg;
    logic [3:0] cnt_reg;

    logic in_run;
    logic req_go;
    logic mem_freeze;
    logic run_gate;
    logic hazard_act;
    logic branch_act;

    assign in_run     = (state_reg == RUN);
    assign req_go     = in_run & start_i & mem_req_i;
    assign mem_freeze = (req_go & MULTI_CYCLE) | (~in_run & (cnt_reg > 4'd1));
    // A stopped CPU only blanks the controls while idle; an access in flight runs to completion.
    assign run_gate   = ~(in_run & ~start_i);
    assign hazard_act = run_gate & ~mem_freeze & hazard_i;
    assign branch_act = run_gate & ~mem_freeze & ~hazard_i & branch_taken_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (req_go && MULTI_CYCLE) begin
                        cnt_reg   <= LAT_M1;
                        state_reg <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (cnt_reg > 4'd1) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        cnt_reg   <= 4'd0;
                        state_reg <= RUN;
                    end
                end
                default: begin
                    cnt_reg   <= 4'd0;
                    state_reg <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        mem_start_o   = 1'b0;
        mem_done_o    = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_noop_o   = 1'b0;
        pipe_freeze_o = 1'b0;
        memwb_noop_o  = 1'b0;
        if (!rst_i) begin
            mem_start_o = req_go;
            mem_done_o  = (~in_run & (cnt_reg == 4'd1)) | (req_go & ~MULTI_CYCLE);
            if (run_gate) begin
                if (mem_freeze) begin
                    pipe_freeze_o = 1'b1;
                    memwb_noop_o  = 1'b1;
                end else if (hazard_act) begin
                    idex_noop_o = 1'b1;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    ifid_flush_o = branch_act;
                end
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [2:0]       perf_evt;
    logic [CNT_W-1:0] perf_cnt_reg [3];

    assign perf_evt = {mem_freeze, branch_act, hazard_act};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_evt[gi] && (perf_cnt_reg[gi] != '1)) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cycles_o    = perf_cnt_reg[0];
    assign flush_count_o     = perf_cnt_reg[1];
    assign mem_wait_cycles_o = perf_cnt_reg[2];
`else
    assign stall_cycles_o    = '0;
    assign flush_count_o     = '0;
    assign mem_wait_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// Instance a uses MEM_LATENCY=4, CNT_W=32; instance b uses MEM_LATENCY=1, CNT_W=2.
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, hazard, branch, mreq;

    logic        a_ms, a_md, a_pc, a_iw, a_if, a_nop, a_frz, a_wb;
    logic [31:0] a_stall, a_flush, a_wait;
    logic        b_ms, b_md, b_pc, b_iw, b_if, b_nop, b_frz, b_wb;
    logic [1:0]  b_stall, b_flush, b_wait;

    pipeline_stall_controller #(.MEM_LATENCY(4), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_i(hazard),
        .branch_taken_i(branch), .mem_req_i(mreq),
        .mem_start_o(a_ms), .mem_done_o(a_md), .pc_write_o(a_pc), .ifid_write_o(a_iw),
        .ifid_flush_o(a_if), .idex_noop_o(a_nop), .pipe_freeze_o(a_frz), .memwb_noop_o(a_wb),
        .stall_cycles_o(a_stall), .flush_count_o(a_flush), .mem_wait_cycles_o(a_wait)
    );

    pipeline_stall_controller #(.MEM_LATENCY(1), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hazard_i(hazard),
        .branch_taken_i(branch), .mem_req_i(mreq),
        .mem_start_o(b_ms), .mem_done_o(b_md), .pc_write_o(b_pc), .ifid_write_o(b_iw),
        .ifid_flush_o(b_if), .idex_noop_o(b_nop), .pipe_freeze_o(b_frz), .memwb_noop_o(b_wb),
        .stall_cycles_o(b_stall), .flush_count_o(b_flush), .mem_wait_cycles_o(b_wait)
    );

    // Output bit order: {mem_start, mem_done, pc_write, ifid_write, ifid_flush, idex_noop, pipe_freeze, memwb_noop}
    localparam logic [7:0] ZERO   = 8'b0000_0000;
    localparam logic [7:0] NORM   = 8'b0011_0000;
    localparam logic [7:0] FRZ    = 8'b0000_0011;
    localparam logic [7:0] FRZ_ST = 8'b1000_0011;
    localparam logic [7:0] DONE   = 8'b0111_0000;
    localparam logic [7:0] HAZ    = 8'b0000_0100;
    localparam logic [7:0] HAZ_DN = 8'b0100_0100;
    localparam logic [7:0] BR     = 8'b0011_1000;
    localparam logic [7:0] LAT1   = 8'b1111_0000;

    // which: 0 = a outputs, 1 = b outputs, 2 = b stall count, 3 = a mem-wait count, 4 = a stall count
    typedef struct {
        int          which;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic vec(input logic r, input logic s, input logic h, input logic b, input logic m,
                       input int which, input logic [7:0] e, input string name);
        exp_t t;
        @(posedge clk);
        #1;
        rst = r; start = s; hazard = h; branch = b; mreq = m;
        t.which = which; t.exp = {24'd0, e}; t.name = name;
        q.push_back(t);
    endtask

    // Queued after a vec: compared at that vec's negedge.
    task automatic chk_cnt(input int which, input logic [31:0] e, input string name);
        exp_t t;
        t.which = which; t.exp = e; t.name = name;
        q.push_back(t);
    endtask

    initial begin : monitor
        exp_t        t;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                t = q.pop_front();
                case (t.which)
                    0:       got = {24'd0, a_ms, a_md, a_pc, a_iw, a_if, a_nop, a_frz, a_wb};
                    1:       got = {24'd0, b_ms, b_md, b_pc, b_iw, b_if, b_nop, b_frz, b_wb};
                    2:       got = {30'd0, b_stall};
                    3:       got = a_wait;
                    default: got = a_stall;
                endcase
                n_cmp++;
                if (got !== t.exp) begin
                    n_fail++;
                    $display("FAIL vec %0d %s: got %h expected %h", n_cmp, t.name, got, t.exp);
                end else begin
                    $display("vec %0d %s: got %h ok", n_cmp, t.name, got);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] exp_mwait;
        logic [31:0] exp_bstall;
        logic [31:0] exp_astall;
        int          guard;
`ifdef STALL_PERF_CNT_EN
        exp_mwait  = 32'd6;
        exp_bstall = 32'd3;
        exp_astall = 32'd5;
`else
        exp_mwait  = 32'd0;
        exp_bstall = 32'd0;
        exp_astall = 32'd0;
`endif
        rst = 1'b1; start = 1'b0; hazard = 1'b0; branch = 1'b0; mreq = 1'b0;

        // Reset: everything low regardless of inputs
        vec(1, 0, 0, 0, 0, 0, ZERO, "reset_idle");
        vec(1, 1, 1, 1, 1, 0, ZERO, "reset_all_in_a");
        vec(1, 1, 1, 1, 1, 1, ZERO, "reset_all_in_b");
        vec(0, 0, 1, 1, 1, 0, ZERO, "not_started");

        // Single load, latency 4
        vec(0, 1, 0, 0, 1, 0, FRZ_ST, "load_c0");
        vec(0, 1, 0, 0, 1, 0, FRZ,    "load_c1");
        vec(0, 1, 0, 0, 1, 0, FRZ,    "load_c2");
        vec(0, 1, 0, 0, 1, 0, DONE,   "load_c3");
        vec(0, 1, 0, 0, 0, 0, NORM,   "load_after");

        // Back-to-back loads from a clean counter
        vec(1, 0, 0, 0, 0, 0, ZERO, "b2b_reset");
        for (int i = 0; i < 2; i++) begin
            vec(0, 1, 0, 0, 1, 0, FRZ_ST, "b2b_start");
            vec(0, 1, 0, 0, 1, 0, FRZ,    "b2b_wait1");
            vec(0, 1, 0, 0, 1, 0, FRZ,    "b2b_wait2");
            vec(0, 1, 0, 0, 1, 0, DONE,   "b2b_done");
        end
        vec(0, 1, 0, 0, 0, 0, NORM, "b2b_after");
        chk_cnt(3, exp_mwait, "mem_wait_cycles");

        // start_i and mem_req_i drop mid-access: access still completes
        vec(0, 1, 0, 0, 1, 0, FRZ_ST, "drop_c0");
        vec(0, 0, 0, 0, 0, 0, FRZ,    "drop_c1");
        vec(0, 0, 0, 0, 0, 0, FRZ,    "drop_c2");
        vec(0, 0, 0, 0, 0, 0, DONE,   "drop_c3");
        vec(0, 0, 0, 0, 0, 0, ZERO,   "drop_idle");

        // Reset mid-wait abandons the access
        vec(0, 1, 0, 0, 1, 0, FRZ_ST, "rmid_c0");
        vec(0, 1, 0, 0, 1, 0, FRZ,    "rmid_c1");
        vec(1, 1, 0, 0, 1, 0, ZERO,   "rmid_reset");
        vec(0, 1, 0, 0, 0, 0, NORM,   "rmid_after");
        vec(0, 1, 0, 0, 0, 0, NORM,   "rmid_no_done");

        // Load-use with branch: branch waits for the load
        vec(0, 1, 1, 1, 0, 0, HAZ, "lu_branch");
        vec(0, 1, 0, 1, 0, 0, BR,  "branch_flush");

        // Freeze masks hazard and branch
        vec(0, 1, 1, 0, 1, 0, FRZ_ST, "mask_c0");
        vec(0, 1, 1, 1, 0, 0, FRZ,    "mask_c1");
        vec(0, 1, 1, 0, 0, 0, FRZ,    "mask_c2");
        vec(0, 1, 1, 0, 0, 0, HAZ_DN, "mask_done");
        vec(0, 1, 1, 0, 0, 0, HAZ,    "mask_after");
        vec(0, 1, 0, 0, 0, 0, NORM,   "mask_clear");

        // Saturating stall counter (CNT_W=2 on b) and unsaturated on a
        vec(1, 0, 0, 0, 0, 1, ZERO, "cnt_reset");
        for (int i = 0; i < 5; i++) vec(0, 1, 1, 0, 0, 1, HAZ, "cnt_hazard");
        vec(0, 1, 0, 0, 0, 1, NORM, "cnt_norm");
        chk_cnt(2, exp_bstall, "stall_sat_b");
        chk_cnt(4, exp_astall, "stall_a");

        // Latency 1: start and done together, never frozen
        vec(0, 1, 0, 0, 1, 1, LAT1, "lat1_load0");
        vec(0, 1, 0, 0, 1, 1, LAT1, "lat1_load1");
        vec(0, 1, 0, 0, 0, 1, NORM, "lat1_after");

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, 0 required", q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
